// File: rtl/alu_sequencer.sv
// Instruction-issuing front end for the 4-bit add/subtract ALU: accepts 8-bit
// instructions and drives the ALU from an accumulator. It also checks the ALU result.
module alu_sequencer (
    input  logic       clock,
    input  logic       resetn,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_ain,
    output logic [3:0] alu_bin,
    input  logic [3:0] alu_out,
    output logic [3:0] acc,
    output logic       carry,
    output logic       done,
    output logic       halted,
    output logic       err,
    output logic [7:0] retired
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_LDI  = 4'b0011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_HALT} state_t;

    state_t     state_q, state_d;
    logic [3:0] opcode_q, ain_q, bin_q, acc_q;
    logic [4:0] exp_q;
    logic       carry_q, done_q, err_q;
    logic [7:0] retired_q;

    logic [3:0] op, imm;
    logic       accept, is_arith, retire;

    assign op       = instr[7:4];
    assign imm      = instr[3:0];
    assign accept   = instr_valid && (state_q == S_IDLE);
    assign is_arith = (op == OP_ADD) || (op == OP_SUB);
    // ADD/SUB retire when CAPTURE ends; everything else retires on acceptance.
    assign retire   = (accept && !is_arith) || (state_q == S_CAPTURE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_arith) begin
                        state_d = S_ISSUE;
                    end else if (op == OP_HALT) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_IDLE;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == S_IDLE);
        halted      = (state_q == S_HALT);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            opcode_q  <= 4'h0;
            ain_q     <= 4'h0;
            bin_q     <= 4'h0;
            acc_q     <= 4'h0;
            exp_q     <= 5'h00;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= 8'h00;
        end else begin
            done_q    <= retire;
            retired_q <= retired_q + {7'b0, retire};
            if (accept) begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        opcode_q <= op;
                        ain_q    <= acc_q;
                        bin_q    <= imm;
                        exp_q    <= (op == OP_ADD) ? ({1'b0, acc_q} + {1'b0, imm})
                                                   : ({1'b0, acc_q} - {1'b0, imm});
                    end
                    OP_LDI:          acc_q <= imm;
                    OP_NOP, OP_HALT: ;
                    default:         err_q <= 1'b1;
                endcase
            end
            if (state_q == S_ISSUE) begin
                opcode_q <= OP_NOP;
            end
            if (state_q == S_CAPTURE) begin
                acc_q   <= alu_out;
                carry_q <= exp_q[4];
                if (alu_out != exp_q[3:0]) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign alu_opcode = opcode_q;
    assign alu_ain    = ain_q;
    assign alu_bin    = bin_q;
    assign acc        = acc_q;
    assign carry      = carry_q;
    assign done       = done_q;
    assign err        = err_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered ALU model and a scoreboard
// of expected retirement state popped on every done pulse.
module tb_alu_sequencer;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       instr_valid = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       instr_ready;
    logic [3:0] alu_opcode, alu_ain, alu_bin;
    logic [3:0] alu_out = 4'h0;
    logic [3:0] acc;
    logic       carry, done, halted, err;
    logic [7:0] retired;
    logic       fault = 1'b0;

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock(clock), .resetn(resetn), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_opcode(alu_opcode), .alu_ain(alu_ain),
        .alu_bin(alu_bin), .alu_out(alu_out), .acc(acc), .carry(carry), .done(done),
        .halted(halted), .err(err), .retired(retired)
    );

    // ALU: samples opcode/operands at the clock edge and registers the result.
    always @(posedge clock) begin
        case (alu_opcode)
            4'b0001: alu_out <= fault ? ((alu_ain + alu_bin) ^ 4'h1) : (alu_ain + alu_bin);
            4'b0010: alu_out <= alu_ain - alu_bin;
            default: alu_out <= alu_out;
        endcase
    end

    typedef struct packed {
        logic [3:0] acc;
        logic       carry;
        logic       err;
        logic [7:0] ret;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] m_acc = 4'h0;
    logic       m_carry = 1'b0;
    logic       m_err = 1'b0;
    logic [7:0] m_ret = 8'h00;
    int vectors = 0, miscompares = 0;
    int op_cycles = 0, ready_low = 0, done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (alu_opcode != 4'h0) op_cycles++;
        if (instr_ready !== 1'b1) ready_low++;
        if (done === 1'b1) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("done_acc", acc, e.acc);
                chk("done_carry", carry, e.carry);
                chk("done_err", err, e.err);
                chk("done_retired", retired, e.ret);
            end
        end
    endtask

    task automatic model_push(input logic [3:0] op, input logic [3:0] imm);
        logic [4:0] r;
        case (op)
            4'h1: begin
                r = {1'b0, m_acc} + {1'b0, imm};
                m_acc = fault ? (r[3:0] ^ 4'h1) : r[3:0];
                if (fault) m_err = 1'b1;
                m_carry = r[4];
            end
            4'h2: begin
                r = {1'b0, m_acc} - {1'b0, imm};
                m_acc = r[3:0];
                m_carry = r[4];
            end
            4'h3: m_acc = imm;
            4'h0, 4'hF: ;
            default: m_err = 1'b1;
        endcase
        m_ret = m_ret + 8'h01;
        sbq.push_back({m_acc, m_carry, m_err, m_ret});
    endtask

    // Offers an instruction and returns 1 time unit after its accept edge, valid still high.
    task automatic send(input logic [3:0] op, input logic [3:0] imm);
        int n;
        tick();
        instr = {op, imm};
        instr_valid = 1'b1;
        model_push(op, imm);
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("accept_timeout", 0, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        instr_valid = 1'b0;
        n = 0;
        while (sbq.size() > 0 && n < 30) begin
            tick();
            n++;
        end
        if (sbq.size() > 0) chk("drain_timeout", sbq.size(), 0);
    endtask

    task automatic model_reset();
        sbq.delete();
        m_acc = 4'h0; m_carry = 1'b0; m_err = 1'b0; m_ret = 8'h00;
    endtask

    task automatic do_reset();
        instr_valid = 1'b0;
        resetn = 1'b0;
        model_reset();
        #2;
        chk("rst_acc", acc, 0);
        chk("rst_err", err, 0);
        chk("rst_retired", retired, 0);
        chk("rst_halted", halted, 0);
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_ready", instr_ready, 1);
        chk("rst_opcode", alu_opcode, 0);
        chk("rst_ain", alu_ain, 0);
        chk("rst_bin", alu_bin, 0);
        chk("rst_carry", carry, 0);
        chk("rst_done", done, 0);

        // LDI 3, ADD 4
        op_cycles = 0; done_cnt = 0;
        send(4'h3, 4'h3);
        chk("ldi_acc_at_accept", acc, 3);
        send(4'h1, 4'h4);
        instr_valid = 1'b0;
        chk("add_opcode", alu_opcode, 4'b0001);
        chk("add_ain", alu_ain, 3);
        chk("add_bin", alu_bin, 4);
        chk("add_ready_low", instr_ready, 0);
        tick();
        tick();
        chk("add_acc_before", acc, 3);
        @(posedge clock); #1;
        chk("add_acc_two_edges", acc, 7);
        drain();
        tick();
        chk("add_op_cycles", op_cycles, 1);
        chk("add_done_pulses", done_cnt, 2);
        chk("add_carry", carry, 0);
        chk("add_retired", retired, 2);

        // Wrap cases
        send(4'h3, 4'hF);
        send(4'h1, 4'h1);
        drain();
        chk("wrap_add_acc", acc, 0);
        chk("wrap_add_carry", carry, 1);
        send(4'h2, 4'h1);
        drain();
        chk("wrap_sub_acc", acc, 4'hF);
        chk("wrap_sub_carry", carry, 1);
        send(4'h2, 4'h5);
        drain();
        chk("sub5_acc", acc, 4'hA);
        chk("sub5_carry", carry, 0);
        chk("wrap_err", err, 0);

        // Queued instructions with instr_valid held high
        ready_low = 0; op_cycles = 0;
        send(4'h1, 4'h2);
        send(4'h2, 4'h1);
        send(4'h0, 4'h0);
        drain();
        tick();
        chk("queue_ready_low", ready_low, 4);
        chk("queue_op_cycles", op_cycles, 2);
        chk("queue_acc", acc, 4'hB);
        chk("queue_retired", retired, m_ret);

        // Faulty ALU on ADD
        fault = 1'b1;
        send(4'h1, 4'h2);
        instr_valid = 1'b0;
        tick();
        tick();
        chk("fault_err_before", err, 0);
        @(posedge clock); #1;
        chk("fault_err_at_capture", err, 1);
        chk("fault_acc", acc, 4'hC);
        drain();
        fault = 1'b0;
        send(4'h0, 4'h0);
        drain();
        chk("fault_err_sticky", err, 1);

        // Reset during CAPTURE of an ADD
        send(4'h1, 4'h1);
        instr_valid = 1'b0;
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("arst_acc", acc, 0);
        chk("arst_carry", carry, 0);
        chk("arst_err", err, 0);
        chk("arst_retired", retired, 0);
        chk("arst_done", done, 0);
        chk("arst_opcode", alu_opcode, 0);
        chk("arst_ain", alu_ain, 0);
        chk("arst_bin", alu_bin, 0);
        chk("arst_ready", instr_ready, 1);
        tick();
        tick();
        resetn = 1'b1;
        send(4'h3, 4'h6);
        drain();
        chk("arst_ldi_acc", acc, 6);
        chk("arst_ldi_retired", retired, 1);

        // Illegal opcode, HALT, then an ADD that must never be taken
        do_reset();
        send(4'h5, 4'h7);
        send(4'hF, 4'h0);
        done_cnt = 0;
        instr = {4'h1, 4'h1};
        for (int i = 0; i < 10; i++) tick();
        chk("halt_ready", instr_ready, 0);
        chk("halt_halted", halted, 1);
        chk("halt_err", err, 1);
        chk("halt_acc", acc, 0);
        chk("halt_retired", retired, 2);
        chk("halt_done_once", done_cnt, 1);
        chk("halt_queue_empty", sbq.size(), 0);
        instr_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
